lsu_dm_master: RTL and testbench

- Load/store initiator between the MEM pipeline stage and the word-wide data memory.
- The data memory has word writes only and a combinational read. This block therefore provides byte and halfword loads and stores (sign/zero extension, read-modify-write for sub-word stores), alignment checking, and a busy/response handshake back to the pipeline.
- Sits in the MEM stage, driving the data memory's addr/data_in/MemWrite/MemRead and consuming its data_out.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_dm_master_lane.sv | 16 +
 rtl/lsu_dm_master.sv | 110 +++++++++++
 tb/tb_lsu_dm_master.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, LSU state enumeration and little-endian lane helpers
package lsu_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STORE, S_RMW_RD, S_RMW_WR, S_ERR} state_t;

    function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] off,
                                                 input logic [1:0] sz, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        return sz == SZ_BYTE ? {{24{sgn & b[7]}}, b} :
               sz == SZ_HALF ? {{16{sgn & h[15]}}, h} : w;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [1:0] off,
                                               input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        if (sz == SZ_BYTE)
            r[{off, 3'b000} +: 8] = d[7:0];
        else if (sz == SZ_HALF)
            r[{off[1], 4'b0000} +: 16] = d[15:0];
        else
            r = d;
        return r;
    endfunction
endpackage

// File: rtl/lsu_dm_master_lane.sv
// lsu_lane_unit: combinational load extract/extend and sub-word store merge
module lsu_lane_unit (
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_buf,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);
    import lsu_pkg::*;

    assign o_load  = lane_extract(i_rdata, i_off, i_size, i_signed);
    assign o_merge = lane_merge(i_buf, i_off, i_size, i_wdata);
endmodule

// File: rtl/lsu_dm_master.sv
// lsu_dm_master: MEM-stage load/store initiator for a word-only data memory.
// Define LSU_TRACE_EN to print writes, completed loads and errors.
module lsu_dm_master #(
    parameter int DM_AW       = 10,
    parameter bit RANGE_CHECK = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        busy,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic        dm_we,
    output logic        dm_re,
    input  logic [31:0] dm_rdata
);
    import lsu_pkg::*;

    state_t      r_state, w_next;
    logic [31:0] r_addr, r_wdata, r_buf, r_resp_rdata;
    logic [1:0]  r_size;
    logic        r_signed, r_write, r_resp_valid, r_resp_err;
    logic        w_req_err, w_done;
    logic [31:0] w_load, w_merge;

    assign w_req_err = req_size == 2'b11 || (req_size == SZ_HALF && req_addr[0]) ||
                       (req_size == SZ_WORD && req_addr[1:0] != 2'b00) ||
                       (RANGE_CHECK && req_addr[31:DM_AW+2] != '0);
    assign w_done    = r_state == S_LOAD || r_state == S_STORE || r_state == S_RMW_WR || r_state == S_ERR;

    lsu_lane_unit u_lane (
        .i_rdata (dm_rdata),
        .i_buf   (r_buf),
        .i_off   (r_addr[1:0]),
        .i_size  (r_size),
        .i_signed(r_signed),
        .i_wdata (r_wdata),
        .o_load  (w_load),
        .o_merge (w_merge)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (req_valid) w_next = w_req_err ? S_ERR : !req_write ? S_LOAD :
                                              req_size == SZ_WORD ? S_STORE : S_RMW_RD;
            S_RMW_RD: w_next = S_RMW_WR;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_size       <= '0;
            r_signed     <= 1'b0;
            r_write      <= 1'b0;
            r_buf        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= w_done;
            r_resp_err   <= r_state == S_ERR;
            if (r_state == S_IDLE && req_valid) begin
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_write  <= req_write;
            end
            if (r_state == S_RMW_RD) r_buf <= dm_rdata;
            if (w_done) r_resp_rdata <= r_state == S_LOAD ? w_load : '0;
        end
    end

    assign req_ready  = r_state == S_IDLE;
    assign busy       = ~req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign dm_addr    = {r_addr[31:2], 2'b00};
    assign dm_we      = r_write && (r_state == S_STORE || r_state == S_RMW_WR);
    assign dm_re      = r_state == S_LOAD || r_state == S_RMW_RD;
    assign dm_wdata   = r_state == S_RMW_WR ? w_merge : r_wdata;

`ifdef LSU_TRACE_EN
    always_ff @(posedge clk) begin
        if (dm_we) $display("lsu store addr=%h size=%0d word=%h", r_addr, r_size, dm_wdata);
        if (r_state == S_LOAD) $display("lsu load addr=%h rdata=%h", r_addr, w_load);
        if (r_state == S_ERR)
            $display("lsu error addr=%h cause=%s", r_addr, r_size == 2'b11 ? "size" :
                     (RANGE_CHECK && r_addr[31:DM_AW+2] != '0) ? "range" : "align");
    end
`endif
endmodule

// File: tb/tb_lsu_dm_master.sv
// tb_lsu_dm_master: randomized scoreboard bench with a byte-array reference memory
module tb_lsu_dm_master;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, busy, dm_we, dm_re;
    logic [31:0] resp_rdata, dm_addr, dm_wdata, dm_rdata;

    always #5 clk = ~clk;

    lsu_dm_master dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_err(resp_err), .resp_rdata(resp_rdata), .busy(busy), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_re(dm_re), .dm_rdata(dm_rdata)
    );

    logic [31:0] mem [1024];
    assign dm_rdata = mem[dm_addr[11:2]];
    always @(posedge clk) if (dm_we) mem[dm_addr[11:2]] <= dm_wdata;

    logic [7:0] ref_b [4096];

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic [31:0] waddr;
        int          lat;
        int          acc;
        int          n_re;
        int          n_we;
    } exp_t;

    exp_t q[$];
    int n_chk = 0, n_fail = 0, cyc = 0, last_resp = -100, re_cnt = 0, we_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: byte-addressed memory, spec latency counted in cycles after the accepting edge.
    function automatic exp_t model(input logic wr, input logic [1:0] sz, input logic sg,
                                   input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int n;
        longint v;
        n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        v = 0;
        e.err = sz == 2'd3 || (a % n) != 0 || a >= 32'd4096;
        e.rdata = '0;
        e.waddr = a & ~32'h3;
        e.lat = 2;
        e.acc = 0;
        e.n_re = 0;
        e.n_we = 0;
        if (!e.err) begin
            if (wr) begin
                for (int i = 0; i < n; i++) ref_b[a + i] = 8'(wd >> (8 * i));
                e.n_we = 1;
                if (n < 4) begin
                    e.n_re = 1;
                    e.lat = 3;
                end
            end else begin
                for (int i = 0; i < n; i++) v += longint'(ref_b[a + i]) << (8 * i);
                if (sg && v >= (64'sd1 <<< (8 * n - 1))) v -= (64'sd1 <<< (8 * n));
                e.rdata = 32'(v);
                e.n_re = 1;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            re_cnt = 0;
            we_cnt = 0;
        end else begin
            if (dm_we || dm_re) begin
                chk("dm_we_re_exclusive", 32'(dm_we & dm_re), 32'd0);
                re_cnt += int'(dm_re);
                we_cnt += int'(dm_we);
                if (q.size() != 0) chk("dm_addr", dm_addr, q[0].waddr);
            end
            if (resp_valid) begin
                if (q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("resp_err", 32'(resp_err), 32'(e.err));
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                    chk("dm_re_cycles", 32'(re_cnt), 32'(e.n_re));
                    chk("dm_we_cycles", 32'(we_cnt), 32'(e.n_we));
                end
                re_cnt = 0;
                we_cnt = 0;
                last_resp = cyc;
            end
        end
    end

    // Called at a negedge; presents junk while busy, returns at the negedge after acceptance.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input bit track,
                         output int acc);
        int t;
        t = 0;
        while (!req_ready && t < 50) begin
            chk("busy_vs_ready", 32'(busy), 32'd1);
            req_valid  = 1'($urandom);
            req_write  = 1'($urandom);
            req_size   = 2'($urandom);
            req_signed = 1'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
            t++;
            @(negedge clk);
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        acc = cyc + 1;
        if (track) begin
            exp_t e;
            e = model(wr, sz, sg, a, wd);
            e.acc = acc;
            q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int acc, acc2, mism;
        logic [31:0] w, a, saved;
        logic [1:0] sz;
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            mem[i] = w;
            for (int k = 0; k < 4; k++) ref_b[4 * i + k] = 8'(w >> (8 * k));
        end
        repeat (3) @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_dm_we", 32'(dm_we), 32'd0);
        chk("rst_dm_re", 32'(dm_re), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dm_addr", dm_addr, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 1, acc);
        issue(0, 2'd2, 0, 32'h10, 32'h0, 1, acc);
        issue(1, 2'd2, 0, 32'h20, 32'h11223344, 1, acc);
        issue(1, 2'd0, 0, 32'h21, 32'h000000AA, 1, acc);
        issue(1, 2'd1, 0, 32'h22, 32'h0000BEEF, 1, acc);
        drain();
        chk("rmw_word", mem[32'h20 >> 2], 32'hBEEFAA44);
        chk("store_word", mem[32'h10 >> 2], 32'hDEADBEEF);

        issue(1, 2'd2, 0, 32'h30, 32'h80FF7F01, 1, acc);
        issue(0, 2'd0, 1, 32'h31, 32'h0, 1, acc);
        issue(0, 2'd0, 1, 32'h32, 32'h0, 1, acc);
        issue(0, 2'd0, 0, 32'h33, 32'h0, 1, acc);
        issue(0, 2'd1, 1, 32'h32, 32'h0, 1, acc);
        issue(0, 2'd1, 0, 32'h32, 32'h0, 1, acc);
        drain();

        issue(0, 2'd2, 0, 32'h13, 32'h0, 1, acc);
        issue(1, 2'd1, 0, 32'h15, 32'h5555, 1, acc);
        issue(1, 2'd3, 0, 32'h40, 32'h12345678, 1, acc);
        issue(0, 2'd2, 0, 32'h1000, 32'h0, 1, acc);
        drain();

        issue(0, 2'd2, 0, 32'h44, 32'h0, 1, acc);
        issue(1, 2'd0, 0, 32'h45, 32'h5A, 1, acc2);
        chk("b2b_accept_in_resp_cycle", 32'(acc2), 32'(last_resp + 1));
        issue(1, 2'd2, 0, 32'h48, 32'hCAFEF00D, 1, acc2);
        chk("b2b_accept_after_rmw", 32'(acc2), 32'(last_resp + 1));
        drain();

        saved = mem[32'h50 >> 2];
        issue(1, 2'd0, 0, 32'h51, 32'h77, 0, acc);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_dm_we", 32'(dm_we), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_mem_unchanged", mem[32'h50 >> 2], saved);
        issue(1, 2'd0, 0, 32'h51, 32'h77, 1, acc);
        drain();

        for (int i = 0; i < 300; i++) begin
            sz = $urandom_range(0, 15) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
            a = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 9) < 7) a = a & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 15) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
            issue(1'($urandom), sz, 1'($urandom), a, $urandom, 1, acc);
        end
        drain();

        mism = 0;
        for (int i = 0; i < 1024; i++)
            if (mem[i] !== {ref_b[4 * i + 3], ref_b[4 * i + 2], ref_b[4 * i + 1], ref_b[4 * i]}) mism++;
        chk("mem_final_mismatches", 32'(mism), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
